// File: rtl/echo_buf_pkg.sv
// Shared types and constants for the echo buffer read-side logic.
// Holds buffer geometry, requester identity and the read scheduler FSM encoding.
// Pure declarations; no timing or backpressure of its own.
package echo_buf_pkg;

  localparam int ECHO_AW     = 12;
  localparam int ECHO_DW     = 16;
  localparam int ECHO_RD_LAT = 1;

  typedef enum logic {
    OWN_ACC = 1'b0,
    OWN_UPL = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Round-robin tie break: hand the port to whoever was not served last.
  function automatic owner_e tie_winner_rr(owner_e last_own);
    return (last_own == OWN_UPL) ? OWN_ACC : OWN_UPL;
  endfunction

endpackage

// File: rtl/echo_rd_vld_pipe.sv
// Delays the RAM read strobe together with its owner tag so it lines up with registered read data.
// Latency: DEPTH clocks from vld_i to vld_o (DEPTH = RAM read latency + output register).
// No backpressure: a free-running shift register that accepts one entry per clock.
module echo_rd_vld_pipe
  import echo_buf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   vld_i,
  input  owner_e own_i,
  output logic   vld_o,
  output owner_e own_o
);

  logic [DEPTH-1:0] vld_q;
  owner_e           own_q [DEPTH];

  // Shift {valid, owner} one stage per clock; reset flushes any in-flight reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) own_q[i] <= OWN_ACC;
    end else begin
      vld_q    <= {vld_q[DEPTH-2:0], vld_i};
      own_q[0] <= own_i;
      for (int i = 1; i < DEPTH; i++) own_q[i] <= own_q[i-1];
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign own_o = own_q[DEPTH-1];

endmodule

// File: rtl/echo_rd_sched.sv
// Shares the echo buffer RAM read port between ACC and UPL with length-bounded wrap-around bursts.
// Latency: gnt 1 clk after req in IDLE, first read 1 clk after gnt, data/vld RD_LAT+1 clks after each read.
// Backpressure: requests are held as levels until granted; a burst streams 1 word/clk and cannot stall.
// Tie handling: define ECHO_RD_RR_EN for round-robin, otherwise ACC has fixed priority.
module echo_rd_sched
  import echo_buf_pkg::*;
#(
  parameter int AW     = ECHO_AW,
  parameter int DW     = ECHO_DW,
  parameter int RD_LAT = ECHO_RD_LAT
) (
  input  logic          clkin_i,
  input  logic          rst_n_i,
  input  logic          acc_req_i,
  input  logic          upl_req_i,
  input  logic [AW-1:0] acc_start_i,
  input  logic [AW-1:0] upl_start_i,
  input  logic [AW-1:0] acc_len_i,
  input  logic [AW-1:0] upl_len_i,
  output logic          acc_gnt_o,
  output logic          upl_gnt_o,
  output logic          acc_done_o,
  output logic          upl_done_o,
  output logic          ram_rd_en_o,
  output logic [AW-1:0] ram_addr_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic [DW-1:0] rd_data_o,
  output logic          acc_vld_o,
  output logic          upl_vld_o,
  output logic          busy_o
);

  localparam int DRW = 3;

  state_e          state_q;
  owner_e          owner_q;
  owner_e          win_d;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   rem_q;
  logic [DRW-1:0]  drain_q;
  logic            acc_gnt_q, upl_gnt_q;
  logic            acc_done_q, upl_done_q;
  logic            busy_q;
  logic            rd_en_q;
  logic [AW-1:0]   ram_addr_q;
  logic [DW-1:0]   rd_data_q;
  logic            pipe_vld;
  owner_e          pipe_own;

`ifdef ECHO_RD_RR_EN
  owner_e          last_own_q;

  // Pick the next owner; ties go to whichever requester was not served last.
  always_comb begin
    win_d = OWN_ACC;
    if (acc_req_i && upl_req_i) win_d = tie_winner_rr(last_own_q);
    else if (upl_req_i)         win_d = OWN_UPL;
  end

  // Remember the most recent grant for the next tie; first tie after reset goes to ACC.
  always_ff @(posedge clkin_i or negedge rst_n_i) begin
    if (!rst_n_i)                                        last_own_q <= OWN_UPL;
    else if (state_q == ST_IDLE && (acc_req_i || upl_req_i)) last_own_q <= win_d;
  end
`else
  // Pick the next owner; ACC always wins a tie.
  always_comb begin
    win_d = OWN_ACC;
    if (!acc_req_i && upl_req_i) win_d = OWN_UPL;
  end
`endif

  // Burst FSM with registered grant, read, done and busy outputs.
  always_ff @(posedge clkin_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_ACC;
      addr_q     <= '0;
      rem_q      <= '0;
      drain_q    <= '0;
      acc_gnt_q  <= 1'b0;
      upl_gnt_q  <= 1'b0;
      acc_done_q <= 1'b0;
      upl_done_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      acc_gnt_q <= 1'b0;
      upl_gnt_q <= 1'b0;
      rd_en_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (acc_req_i || upl_req_i) begin
            owner_q   <= win_d;
            acc_gnt_q <= (win_d == OWN_ACC);
            upl_gnt_q <= (win_d == OWN_UPL);
            addr_q    <= (win_d == OWN_ACC) ? acc_start_i : upl_start_i;
            rem_q     <= (win_d == OWN_ACC) ? acc_len_i : upl_len_i;
            busy_q    <= 1'b1;
            state_q   <= ST_BURST;
          end
        end
        ST_BURST: begin
          rd_en_q    <= 1'b1;
          ram_addr_q <= addr_q;
          addr_q     <= addr_q + AW'(1);
          rem_q      <= rem_q - AW'(1);
          if (rem_q == '0) begin
            drain_q <= DRW'(RD_LAT + 1);
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Count out the reads still in the RAM and output register, then pulse done once.
          if (acc_done_q || upl_done_q) begin
            acc_done_q <= 1'b0;
            upl_done_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (drain_q == '0) begin
            acc_done_q <= (owner_q == OWN_ACC);
            upl_done_q <= (owner_q == OWN_UPL);
          end else begin
            drain_q <= drain_q - DRW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Register RAM read data so it aligns with the delayed valid strobe.
  always_ff @(posedge clkin_i or negedge rst_n_i) begin
    if (!rst_n_i) rd_data_q <= '0;
    else          rd_data_q <= ram_rdata_i;
  end

  echo_rd_vld_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_vld_pipe (
    .clk_i   (clkin_i),
    .rst_n_i (rst_n_i),
    .vld_i   (rd_en_q),
    .own_i   (owner_q),
    .vld_o   (pipe_vld),
    .own_o   (pipe_own)
  );

  assign acc_gnt_o   = acc_gnt_q;
  assign upl_gnt_o   = upl_gnt_q;
  assign acc_done_o  = acc_done_q;
  assign upl_done_o  = upl_done_q;
  assign busy_o      = busy_q;
  assign ram_rd_en_o = rd_en_q;
  assign ram_addr_o  = ram_addr_q;
  assign rd_data_o   = rd_data_q;
  assign acc_vld_o   = pipe_vld && (pipe_own == OWN_ACC);
  assign upl_vld_o   = pipe_vld && (pipe_own == OWN_UPL);

endmodule

// File: tb/tb_echo_rd_sched.sv
// Scoreboard bench for echo_rd_sched: driver pushes expected bursts, monitor checks RAM reads, data, vld, done.
// RAM is modelled with RD_LAT clocks of read latency over a randomly filled array.
// Expectations come from burst arithmetic (start+i mod depth) and the grant rule, not from the DUT.
module tb_echo_rd_sched;
  import echo_buf_pkg::*;

  localparam int AW     = 12;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b1;
  logic          acc_req_i = 1'b0, upl_req_i = 1'b0;
  logic [AW-1:0] acc_start_i = '0, upl_start_i = '0, acc_len_i = '0, upl_len_i = '0;
  logic          acc_gnt_o, upl_gnt_o, acc_done_o, upl_done_o, ram_rd_en_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_rdata_i, rd_data_o;
  logic          acc_vld_o, upl_vld_o, busy_o;

  echo_rd_sched #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clkin_i(clk), .rst_n_i(rst_n_i),
    .acc_req_i(acc_req_i), .upl_req_i(upl_req_i),
    .acc_start_i(acc_start_i), .upl_start_i(upl_start_i),
    .acc_len_i(acc_len_i), .upl_len_i(upl_len_i),
    .acc_gnt_o(acc_gnt_o), .upl_gnt_o(upl_gnt_o),
    .acc_done_o(acc_done_o), .upl_done_o(upl_done_o),
    .ram_rd_en_o(ram_rd_en_o), .ram_addr_o(ram_addr_o), .ram_rdata_i(ram_rdata_i),
    .rd_data_o(rd_data_o), .acc_vld_o(acc_vld_o), .upl_vld_o(upl_vld_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data appears RD_LAT clocks after the enable.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdq [RD_LAT];
  initial for (int i = 0; i < RD_LAT; i++) rdq[i] = '0;
  always @(posedge clk) begin
    if (ram_rd_en_o) rdq[0] <= mem[ram_addr_o];
    for (int i = 1; i < RD_LAT; i++) rdq[i] <= rdq[i-1];
  end
  assign ram_rdata_i = rdq[RD_LAT-1];

  typedef struct {
    owner_e        own;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    bit            first;
    bit            last;
    int            vcyc;
  } exp_t;

  exp_t   rd_q[$];
  exp_t   vld_q[$];
  bit     pend_done = 0;
  int     done_cyc = 0;
  owner_e done_own = OWN_ACC;
  int     busy_chk_cyc = -1;
  int     gnt_cyc_m = -100;
  int     last_rd_cyc = -100;
  owner_e last_own_m = OWN_UPL;
  int     n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not expected or missing (cyc %0d)", nm, cyc);
  endtask

  function automatic logic [1:0] own_bits(owner_e o);
    return (o == OWN_ACC) ? 2'b01 : 2'b10;
  endfunction

  // Reference arbitration: who should get the port given the request levels.
  function automatic owner_e model_pick(bit a, bit u);
    if (a && u) begin
`ifdef ECHO_RD_RR_EN
      return (last_own_m == OWN_ACC) ? OWN_UPL : OWN_ACC;
`else
      return OWN_ACC;
`endif
    end
    return a ? OWN_ACC : OWN_UPL;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a read, a data word or a done.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n_i) begin
      if (acc_gnt_o || upl_gnt_o) gnt_cyc_m = cyc;
      if (acc_done_o || upl_done_o) begin
        if (!pend_done) fail_evt("unexpected_done");
        else begin
          chk("done_owner", {upl_done_o, acc_done_o}, own_bits(done_own));
          chk("done_cyc", cyc, done_cyc);
          chk("busy_at_done", busy_o, 1);
          pend_done = 0;
          busy_chk_cyc = cyc + 1;
        end
      end else if (pend_done && cyc >= done_cyc) begin
        fail_evt("missing_done");
        pend_done = 0;
      end
      if (cyc == busy_chk_cyc) chk("busy_after_done", busy_o, 0);
      if (ram_rd_en_o) begin
        if (rd_q.size() == 0) fail_evt("unexpected_rd_en");
        else begin
          e = rd_q.pop_front();
          chk("ram_addr", ram_addr_o, e.addr);
          if (e.first) chk("first_rd_en_cyc", cyc, gnt_cyc_m + 1);
          else         chk("rd_en_gapless", cyc, last_rd_cyc + 1);
          e.vcyc = cyc + RD_LAT + 1;
          vld_q.push_back(e);
        end
        last_rd_cyc = cyc;
      end
      if (acc_vld_o || upl_vld_o) begin
        if (acc_vld_o && upl_vld_o) fail_evt("both_vld");
        if (vld_q.size() == 0) fail_evt("unexpected_vld");
        else begin
          e = vld_q.pop_front();
          chk("vld_owner", {upl_vld_o, acc_vld_o}, own_bits(e.own));
          chk("rd_data", rd_data_o, e.dat);
          chk("vld_cyc", cyc, e.vcyc);
          if (e.last) begin
            pend_done = 1;
            done_cyc  = cyc + 1;
            done_own  = e.own;
          end
        end
      end else if (vld_q.size() > 0 && vld_q[0].vcyc <= cyc) begin
        fail_evt("missing_vld");
        void'(vld_q.pop_front());
      end
    end
  end

  task automatic push_burst(input owner_e o, input logic [AW-1:0] st, input logic [AW-1:0] ln);
    for (int i = 0; i <= int'(ln); i++) begin
      exp_t e;
      e.own   = o;
      e.addr  = AW'((int'(st) + i) % DEPTH);
      e.dat   = mem[e.addr];
      e.first = (i == 0);
      e.last  = (i == int'(ln));
      e.vcyc  = 0;
      rd_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((busy_o || rd_q.size() != 0 || vld_q.size() != 0 || pend_done) && k < 8000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 8000) fail_evt("idle_timeout");
  endtask

  // Present requests and serve ngr grants; hold keeps both levels up across grants.
  task automatic run_reqs(input bit a_en, input bit u_en,
                          input logic [AW-1:0] a_st, input logic [AW-1:0] a_ln,
                          input logic [AW-1:0] u_st, input logic [AW-1:0] u_ln,
                          input int ngr, input bit hold);
    bit a_on, u_on;
    int k, exp_g;
    owner_e o;
    logic [AW-1:0] ln;
    a_on = a_en;
    u_on = u_en;
    wait_idle();
    acc_start_i = a_st; acc_len_i = a_ln;
    upl_start_i = u_st; upl_len_i = u_ln;
    acc_req_i = a_on; upl_req_i = u_on;
    exp_g = cyc + 1;
    for (int g = 0; g < ngr; g++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(acc_gnt_o || upl_gnt_o) && k < 8000);
      if (!(acc_gnt_o || upl_gnt_o)) begin
        fail_evt("gnt_timeout");
        break;
      end
      o = model_pick(a_on, u_on);
      chk("gnt_owner", {upl_gnt_o, acc_gnt_o}, own_bits(o));
      chk("gnt_cyc", cyc, exp_g);
      chk("busy_at_gnt", busy_o, 1);
      ln = (o == OWN_ACC) ? a_ln : u_ln;
      push_burst(o, (o == OWN_ACC) ? a_st : u_st, ln);
      last_own_m = o;
      exp_g = cyc + int'(ln) + RD_LAT + 5;
      if (!hold) begin
        if (o == OWN_ACC) a_on = 0;
        else              u_on = 0;
      end else if (g == ngr - 1) begin
        a_on = 0;
        u_on = 0;
      end
      acc_req_i = a_on;
      upl_req_i = u_on;
    end
    acc_req_i = 0;
    upl_req_i = 0;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, {ram_rd_en_o, ram_addr_o, rd_data_o, acc_vld_o, upl_vld_o,
             acc_gnt_o, upl_gnt_o, acc_done_o, upl_done_o, busy_o}, 64'd0);
  endtask

  task automatic reset_mid_burst();
    int k, nrd;
    wait_idle();
    acc_start_i = 12'h123; acc_len_i = 12'd7; acc_req_i = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!acc_gnt_o && k < 20);
    chk("rst_test_gnt", acc_gnt_o, 1);
    push_burst(OWN_ACC, 12'h123, 12'd7);
    last_own_m = OWN_ACC;
    acc_req_i = 0;
    nrd = 0;
    k = 0;
    while (nrd < 3 && k < 20) begin
      @(negedge clk);
      k++;
      if (ram_rd_en_o) nrd++;
    end
    chk("rst_test_third_addr", ram_addr_o, 12'h125);
    #2 rst_n_i = 0;
    #1 chk_outputs_zero("outputs_in_reset_midburst");
    rd_q.delete();
    vld_q.delete();
    pend_done = 0;
    busy_chk_cyc = -1;
    last_own_m = OWN_UPL;
    repeat (2) @(negedge clk);
    #2 rst_n_i = 1;
    repeat (12) @(negedge clk);
    chk("no_activity_after_reset", {busy_o, acc_done_o, upl_done_o, acc_vld_o, upl_vld_o}, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    bit a, u;
    int sel;
    logic [AW-1:0] as, al, us, ul;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    #1 rst_n_i = 0;
    #1 chk_outputs_zero("outputs_in_reset");
    repeat (3) @(negedge clk);
    #2 rst_n_i = 1;

    run_reqs(1, 0, 12'h010, 12'd3, 12'h000, 12'd0, 1, 0);   // basic ACC burst
    run_reqs(0, 1, 12'h000, 12'd0, 12'hFFE, 12'd3, 1, 0);   // UPL wrap-around
    run_reqs(1, 1, 12'h040, 12'd2, 12'h200, 12'd4, 3, 1);   // held tie, three grants
    run_reqs(1, 0, 12'h7A5, 12'hFFF, 12'h000, 12'd0, 1, 0); // whole buffer
    reset_mid_burst();
    run_reqs(1, 1, 12'h300, 12'd1, 12'h0F0, 12'd2, 2, 0);   // first tie after reset

    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 2);
      a  = (sel != 1);
      u  = (sel != 0);
      as = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1 - $urandom_range(0, 8)) : AW'($urandom_range(0, DEPTH - 1));
      us = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1 - $urandom_range(0, 8)) : AW'($urandom_range(0, DEPTH - 1));
      al = AW'($urandom_range(0, 31));
      ul = AW'($urandom_range(0, 31));
      run_reqs(a, u, as, al, us, ul, (a && u) ? 2 : 1, 0);
    end

    wait_idle();
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", rd_q.size() + vld_q.size() + int'(pend_done), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
